// File: rtl/i2s_receiver.sv
// I2S clock master and stereo capture: generates SCKI/BCK/LRCK from a free-running
// frame counter and deserialises MSB-first two's-complement samples from din.
module i2s_receiver #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic             bck,
    output logic             lrck,
    output logic             scki,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right
);

    localparam int SLOT_W = CNT_W - 4;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WIDTH);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [WIDTH-1:0]  left_q, left_d;
    logic [WIDTH-1:0]  right_q, right_d;

    logic [SLOT_W-1:0] slot;
    logic              sample_edge;
    logic [WIDTH-1:0]  shifted;

    assign slot        = cnt_q[CNT_W-2:3];
    assign sample_edge = (cnt_q[2:0] == 3'b011);
    assign shifted     = {sr_q[WIDTH-2:0], din};

    // Slot 0 is the I2S one-bit delay; slots past the sample width carry no data.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        sr_d    = sr_q;
        left_d  = left_q;
        right_d = right_q;
        if (sample_edge) begin
            if (slot == '0) begin
                sr_d = '0;
            end else if (slot <= LAST_SLOT) begin
                sr_d = shifted;
                if (slot == LAST_SLOT) begin
                    if (cnt_q[CNT_W-1]) begin
                        right_d = shifted;
                    end else begin
                        left_d = shifted;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            sr_q    <= '0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    // Clock outputs come straight from counter flops so they are glitch-free.
    assign scki  = cnt_q[0];
    assign bck   = cnt_q[2];
    assign lrck  = cnt_q[CNT_W-1];
    assign left  = left_q;
    assign right = right_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: table-driven frames, random frames and a
// mid-frame reset, checked against a slot-level model of the I2S frame.
module tb_i2s_receiver;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         din = 1'b0;
    logic         bck, lrck, scki;
    logic [W-1:0] left, right;

    int n_checks = 0;
    int n_fails  = 0;
    int t_since;
    logic [W-1:0] prev_l = '0;
    logic [W-1:0] prev_r = '0;

    i2s_receiver #(.WIDTH(W), .CNT_W(9)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .bck   (bck),
        .lrck  (lrck),
        .scki  (scki),
        .left  (left),
        .right (right)
    );

    always #5 clk = ~clk;

    // Cycle count since the last reset release; the model's only time base.
    always @(posedge clk or negedge reset) begin
        if (!reset) t_since <= 0;
        else        t_since <= t_since + 1;
    end

    typedef struct {
        string       name;
        logic [31:0] lslots;
        logic [31:0] rslots;
        logic [W-1:0] exp_l;
        logic [W-1:0] exp_r;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slot word: bit 31 is slot 0 (delay slot), then 24 data bits, then 7 trailing slots.
    function automatic logic [31:0] mk(input logic junk, input logic [W-1:0] data, input logic [6:0] trail);
        return {junk, data, trail};
    endfunction

    function automatic logic [W-1:0] model_word(input logic [31:0] slots);
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) w[W-1-i] = slots[30-i];
        return w;
    endfunction

    // Runs one frame starting at frame position 0; stop_at < 512 aborts at that position.
    task automatic run_frame(input string name, input logic [31:0] ls, input logic [31:0] rs,
                             input logic [W-1:0] exp_l, input logic [W-1:0] exp_r,
                             input int stop_at);
        int clk_err = 0;
        int l_err = 0;
        int r_err = 0;
        for (int k = 0; k < 512; k++) begin
            int t;
            int pos;
            int s;
            t   = t_since;
            pos = t % 512;
            if (pos == stop_at) break;
            s   = (pos % 256) / 8;
            din = (pos >= 256) ? rs[31-s] : ls[31-s];
            if (scki !== 1'((t % 2)) || bck !== 1'(((t / 4) % 2)) || lrck !== 1'(((t / 256) % 2)))
                clk_err++;
            if (left  !== ((pos >= 196) ? exp_l : prev_l)) l_err++;
            if (right !== ((pos >= 452) ? exp_r : prev_r)) r_err++;
            if (pos == 195) check({name, " left_before_load"}, 32'(left), 32'(prev_l));
            if (pos == 196) check({name, " left_after_load"}, 32'(left), 32'(exp_l));
            if (pos == 451) check({name, " right_before_load"}, 32'(right), 32'(prev_r));
            if (pos == 452) check({name, " right_after_load"}, 32'(right), 32'(exp_r));
            @(negedge clk);
        end
        check({name, " clock_waveforms_errs"}, 32'(clk_err), 32'd0);
        check({name, " left_track_errs"}, 32'(l_err), 32'd0);
        check({name, " right_track_errs"}, 32'(r_err), 32'd0);
        if (stop_at >= 512) begin
            check({name, " frame_end_left"}, 32'(left), 32'(exp_l));
            check({name, " frame_end_right"}, 32'(right), 32'(exp_r));
            prev_l = exp_l;
            prev_r = exp_r;
        end
    endtask

    task automatic do_reset(input string name);
        reset = 1'b0;
        prev_l = '0;
        prev_r = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check({name, " reset_outputs"}, {27'd0, scki, bck, lrck, |left, |right}, 32'd0);
        end
        reset = 1'b1;
        #1;
        check({name, " cnt_restart"}, 32'(t_since), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 24'hFFFFFF, 24'hFFFFFF};
        vecs[1] = '{"a5_1234", mk(1'b1, 24'hA5A5A5, 7'h00), mk(1'b1, 24'h123456, 7'h00),
                    24'hA5A5A5, 24'h123456};
        vecs[2] = '{"trail_ones", mk(1'b0, 24'h000001, 7'h7F), mk(1'b1, 24'h000001, 7'h7F),
                    24'h000001, 24'h000001};
        vecs[3] = '{"neg_full", mk(1'b1, 24'h800000, 7'h55), mk(1'b0, 24'h7FFFFF, 7'h2A),
                    24'h800000, 24'h7FFFFF};
        vecs[4] = '{"zero_junk", mk(1'b1, 24'h000000, 7'h7F), mk(1'b1, 24'h000000, 7'h7F),
                    24'h000000, 24'h000000};

        do_reset("init");
        for (int i = 0; i < 5; i++)
            run_frame(vecs[i].name, vecs[i].lslots, vecs[i].rslots, vecs[i].exp_l, vecs[i].exp_r, 512);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] ls, rs;
            ls = $urandom;
            rs = $urandom;
            run_frame("random", ls, rs, model_word(ls), model_word(rs), 512);
        end

        // Reset mid right word: the partial sample must never reach the output.
        run_frame("pre_reset", mk(1'b0, 24'h3C3C3C, 7'h00), mk(1'b0, 24'hDEADBE, 7'h00),
                  24'h3C3C3C, 24'hDEADBE, 300);
        do_reset("mid_reset");
        check("mid_reset right_zero", 32'(right), 32'd0);
        run_frame("post_reset", mk(1'b1, 24'h654321, 7'h11), mk(1'b0, 24'h0F0F0F, 7'h00),
                  24'h654321, 24'h0F0F0F, 512);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time %0t expected below 2000000", $time);
        $fatal(1, "watchdog");
    end

endmodule
